psram_qspi_responder: RTL

Synthesizable QSPI PSRAM target that answers the EBh quad-read / 38h quad-write / 35h enter-quad protocol issued by the PSRAM controller. It sits on the device side of the sck/ce_n/dio pins, oversamples the bus with a faster system clock, and maps transactions onto a simple byte-wide synchronous memory port. It is used as the SoC-level PSRAM stand-in for simulation and FPGA bring-up.

---
 rtl/psram_qspi_responder_if.sv | 27 ++
 rtl/psram_qspi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/psram_qspi_responder_if.sv
// Pin-side QSPI bus and byte-wide memory port of the PSRAM responder.
// master = controller/memory side, slave = responder.
interface psram_qspi_responder_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              sck;
    logic              ce_n;
    logic [3:0]        din;
    logic [3:0]        dout;
    logic [3:0]        douten;
    logic              qpi_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;

    modport master (
        output sck, ce_n, din, mem_rdata,
        input  dout, douten, qpi_mode, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  sck, ce_n, din, mem_rdata,
        output dout, douten, qpi_mode, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM target: oversamples sck/ce_n/din with clk and serves EBh quad reads,
// 38h quad writes and 35h/F5h quad-mode entry/exit on a byte-wide memory port.
module psram_qspi_responder #(
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned DUMMY  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    psram_qspi_responder_if.slave io_bus
);
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
    } state_e;

    state_e            r_state;
    logic [1:0]        r_sck_sync;
    logic [1:0]        r_cen_sync;
    logic [3:0]        r_din_s1;
    logic [3:0]        r_din_s2;
    logic              r_sck_prev;
    logic              r_cen_prev;
    logic              r_qpi;
    logic [7:0]        r_cmd;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [7:0]        r_mem_wdata;
    logic              r_re_d;
    logic [7:0]        r_rbuf;
    logic [3:0]        r_nib;
    logic              r_half;
    logic [3:0]        r_dout;
    logic              r_douten;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cen_fall;
    logic              w_cen_rise;
    logic              w_active;
    logic [3:0]        w_din;
    logic [7:0]        w_cmd_next;
    logic              w_cmd_last;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_sck_rise  = r_sck_sync[1] & ~r_sck_prev;
    assign w_sck_fall  = ~r_sck_sync[1] & r_sck_prev;
    assign w_cen_fall  = ~r_cen_sync[1] & r_cen_prev;
    assign w_cen_rise  = r_cen_sync[1] & ~r_cen_prev;
    assign w_active    = ~r_cen_sync[1];
    assign w_din       = r_din_s2;
    assign w_cmd_next  = r_qpi ? {r_cmd[3:0], w_din} : {r_cmd[6:0], w_din[0]};
    assign w_cmd_last  = r_qpi ? (r_cnt == 8'd1) : (r_cnt == 8'd7);
    // Shifting 24 address bits through ADDR_W bits drops the unused upper bits.
    assign w_addr_next = {r_addr[ADDR_W-5:0], w_din};
    assign w_addr_inc  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_sck_sync  <= 2'b00;
            r_cen_sync  <= 2'b11;
            r_din_s1    <= 4'h0;
            r_din_s2    <= 4'h0;
            r_sck_prev  <= 1'b0;
            r_cen_prev  <= 1'b1;
            r_qpi       <= 1'b0;
            r_cmd       <= 8'h00;
            r_cnt       <= 8'h00;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
            r_re_d      <= 1'b0;
            r_rbuf      <= 8'h00;
            r_nib       <= 4'h0;
            r_half      <= 1'b0;
            r_dout      <= 4'h0;
            r_douten    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[0], io_bus.sck};
            r_cen_sync <= {r_cen_sync[0], io_bus.ce_n};
            r_din_s1   <= io_bus.din;
            r_din_s2   <= r_din_s1;
            r_sck_prev <= r_sck_sync[1];
            r_cen_prev <= r_cen_sync[1];
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            // Memory returns data one clk after the strobe; hold it for the nibble shifter.
            r_re_d     <= r_mem_re;
            if (r_re_d) begin
                r_rbuf <= io_bus.mem_rdata;
            end

            if (w_cen_rise) begin
                r_state  <= StIdle;
                r_douten <= 1'b0;
                r_dout   <= 4'h0;
                r_half   <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_cen_fall) begin
                            r_state <= StCmd;
                            r_cnt   <= 8'h00;
                            r_cmd   <= 8'h00;
                        end
                    end
                    StCmd: begin
                        if (w_active && w_sck_rise) begin
                            r_cmd <= w_cmd_next;
                            r_cnt <= r_cnt + 8'd1;
                            if (w_cmd_last) begin
                                r_cnt <= 8'h00;
                                if (!r_qpi && w_cmd_next == 8'h35) begin
                                    r_qpi   <= 1'b1;
                                    r_state <= StIgnore;
                                end else if (r_qpi && w_cmd_next == 8'hF5) begin
                                    r_qpi   <= 1'b0;
                                    r_state <= StIgnore;
                                end else if (r_qpi && (w_cmd_next == 8'hEB ||
                                                       w_cmd_next == 8'h38)) begin
                                    r_state <= StAddr;
                                end else begin
                                    r_state <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddr: begin
                        if (w_active && w_sck_rise) begin
                            r_addr <= w_addr_next;
                            r_cnt  <= r_cnt + 8'd1;
                            if (r_cnt == 8'd5) begin
                                r_cnt <= 8'h00;
                                if (r_cmd == 8'hEB) begin
                                    r_state    <= StDummy;
                                    r_mem_addr <= w_addr_next;
                                    r_mem_re   <= 1'b1;
                                end else begin
                                    r_state <= StWdata;
                                    r_half  <= 1'b0;
                                end
                            end
                        end
                    end
                    StDummy: begin
                        if (w_active && w_sck_rise) begin
                            if (r_cnt == 8'(DUMMY - 1)) begin
                                r_state <= StRdata;
                                r_half  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    StRdata: begin
                        if (w_active && w_sck_fall) begin
                            r_douten <= 1'b1;
                            if (!r_half) begin
                                r_dout <= r_rbuf[7:4];
                                r_half <= 1'b1;
                            end else begin
                                r_dout     <= r_rbuf[3:0];
                                r_half     <= 1'b0;
                                r_addr     <= w_addr_inc;
                                r_mem_addr <= w_addr_inc;
                                r_mem_re   <= 1'b1;
                            end
                        end
                    end
                    StWdata: begin
                        if (w_active && w_sck_rise) begin
                            if (!r_half) begin
                                r_nib  <= w_din;
                                r_half <= 1'b1;
                            end else begin
                                r_mem_wdata <= {r_nib, w_din};
                                r_mem_addr  <= r_addr;
                                r_mem_we    <= 1'b1;
                                r_addr      <= w_addr_inc;
                                r_half      <= 1'b0;
                            end
                        end
                    end
                    StIgnore: begin
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign io_bus.dout      = r_dout;
    assign io_bus.douten    = {4{r_douten}};
    assign io_bus.qpi_mode  = r_qpi;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_re    = r_mem_re;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_wdata = r_mem_wdata;
endmodule
